butterfly_pipe: RTL
===================

// Module: butterfly_pipe
// PURPOSE
//  Pipelined, parametrised modular butterfly for the Kyber NTT/INTT datapath (default Q=3329).
//  Supports Cooley-Tukey (NTT) and Gentleman-Sande (INTT) modes, selectable per sample.
//  Has an optional INTT halving step, a valid/hold handshake and a pass-through tag.
//  Accepts one butterfly per cycle; sits between the coefficient RAM read port and the write-back mux.
// PARAMETERS
//  WID    12    coefficient width; u,t,w,s0,s1 are WID bits
//  Q      3329  modulus; must satisfy Q < 2**WID
//  BK     24    Barrett shift; must be >= 2*WID; localparam M = floor(2**BK / Q)
//  TAG_W  8     width of the sideband tag carried alongside each sample
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous reset, active-low
//  in_valid   in   1      u/t/w/sel/half/in_tag are valid this cycle
//  hold       in   1      1 = freeze the whole pipeline (stall from downstream)
//  sel        in   1      mode: 1 = NTT (CT), 0 = INTT (GS)
//  half       in   1      INTT only: multiply both outputs by 2^-1 mod Q; ignored when sel=1
//  u          in   WID    operand u, required in [0,Q-1]
//  t          in   WID    operand t, required in [0,Q-1]
//  w          in   WID    twiddle, required in [0,Q-1]
//  in_tag     in   TAG_W  sideband tag (e.g. write address)
//  out_valid  out  1      s0/s1/out_tag valid
//  s0         out  WID    first result, in [0,Q-1]
//  s1         out  WID    second result, in [0,Q-1]
//  out_tag    out  TAG_W  in_tag delayed with its sample
// BEHAVIOUR
//  Arithmetic (all results are fully reduced, in [0,Q-1]):
//   NTT : p = w*t mod Q; s0 = (u+p) mod Q; s1 = (u-p) mod Q.
//   INTT: s0 = (u+t) mod Q; s1 = w*((u-t) mod Q) mod Q.
//   If half=1 in INTT, each output x becomes (x even ? x/2 : (x+Q)/2).
//  Modular add/sub: one conditional +/-Q correction; no wider intermediates are kept.
//  Barrett reduction on x < Q**2:
//   r = x - ((x*M)>>BK)*Q, then subtract Q once if r >= Q.
//  Pipeline: fixed latency of 4 enabled cycles.
//   S1 registers u,t,w, the INTT pre-add/sub and the controls.
//   S2 registers the WID x WID product.
//   S3 registers the Barrett result.
//   S4 registers the final add/sub or halving into s0/s1.
//  Every stage carries valid, sel, half and tag; throughput is 1 sample/cycle.
//  hold=1: no register changes, including out_valid/s0/s1/out_tag; in_valid is ignored that cycle.
//   hold=0 resumes with no loss or duplication.
//  Operands and controls are sampled only when in_valid=1 and hold=0.
//   Bubbles propagate as valid=0; data registers of invalid stages may change and are don't-care.
//  Output registers: s0/s1/out_tag update only when the S4 input is valid and hold=0.
//   Otherwise they keep their last value while out_valid drops to 0.
//  Reset (rst=0 at a clock edge) clears all stage valids, out_valid, s0, s1 and out_tag to 0.
//   Reset wins over hold. In-flight samples are discarded, never emitted after reset.
//  sel and half may change every cycle; each sample uses the mode captured with it.
//  Operands >= Q are outside the contract; outputs are unspecified but must not hang the pipeline.
// TESTING
//  1. rst=0 5 cycles, then rst=1
//     -> out_valid=0, s0=s1=out_tag=0 until the first valid sample emerges.
//  2. NTT: u=5, t=7, w=17, tag=0x11
//     -> 4 cycles later out_valid=1, s0=124, s1=3215, out_tag=0x11.
//  3. NTT wrap/max: (u=3328,t=1,w=1) -> s0=0, s1=3327.
//     (u=0,t=3328,w=3328) -> s0=1, s1=3328.
//  4. INTT: u=100, t=50, w=2, half=0 -> s0=150, s1=100; same with half=1 -> s0=75, s1=50.
//     u=0, t=1, w=1, half=1 -> s0=1665, s1=1664.
//  5. Stream 64 back-to-back random samples with alternating sel
//     -> 64 consecutive out_valid, each matching the reference model, tags in order.
//     Insert hold=1 for 3 cycles mid-stream -> outputs frozen, no sample lost or repeated.
//  6. Drive rst=0 with 3 samples in flight
//     -> out_valid stays 0 through and after reset; the next sample emerges 4 cycles after issue.

Source files
------------

// File: rtl/butterfly_pipe_if.sv
// ---------------------------------------------------------------------------
// butterfly_pipe_if
//   Sample/result bundle for the Kyber modular butterfly pipeline.
//   master : issues samples (in_valid, hold, sel, half, u, t, w, in_tag),
//            observes results (out_valid, s0, s1, out_tag).
//   slave  : the butterfly itself.
// ---------------------------------------------------------------------------
interface butterfly_pipe_if #(
    parameter int WID   = 12,
    parameter int TAG_W = 8
);
    logic             in_valid;
    logic             hold;
    logic             sel;
    logic             half;
    logic [WID-1:0]   u;
    logic [WID-1:0]   t;
    logic [WID-1:0]   w;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic [WID-1:0]   s0;
    logic [WID-1:0]   s1;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, hold, sel, half, u, t, w, in_tag,
        input  out_valid, s0, s1, out_tag
    );

    modport slave (
        input  in_valid, hold, sel, half, u, t, w, in_tag,
        output out_valid, s0, s1, out_tag
    );
endinterface

// File: rtl/butterfly_pipe.sv
// ---------------------------------------------------------------------------
// butterfly_pipe
//   Four-stage modular butterfly (CT for NTT, GS for INTT) with Barrett
//   reduction, optional INTT halving, hold-based stall and a sideband tag.
//   Ports:
//     i_clk  : rising-edge clock
//     i_rst  : synchronous reset, active low (wins over hold)
//     bus    : butterfly_pipe_if.slave sample/result bundle
//   Stages:
//     S1 : operands, INTT pre-add/sub, controls
//     S2 : WID x WID product
//     S3 : Barrett-reduced product
//     S4 : final add/sub or halving -> s0/s1/out_tag (output registers)
// ---------------------------------------------------------------------------
module butterfly_pipe #(
    parameter int WID   = 12,
    parameter int Q     = 3329,
    parameter int BK    = 24,
    parameter int TAG_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    butterfly_pipe_if.slave   bus
);
    localparam int           PW  = 2 * WID;
    localparam int           XW  = PW + BK;
    localparam longint       M_L = (longint'(1) <<< BK) / Q;
    localparam logic [XW-1:0] M  = XW'(M_L);
    localparam logic [WID-1:0] QV = WID'(Q);

    // One conditional correction each; the sum needs a single carry bit.
    function automatic logic [WID-1:0] mod_add(input logic [WID-1:0] a, input logic [WID-1:0] b);
        logic [WID:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, QV})
            s = s - {1'b0, QV};
        return s[WID-1:0];
    endfunction

    // a < b: a - b + Q lies in [0,Q-1], so WID-bit wraparound is exact.
    function automatic logic [WID-1:0] mod_sub(input logic [WID-1:0] a, input logic [WID-1:0] b);
        return (a >= b) ? (a - b) : (a - b + QV);
    endfunction

    // x * 2^-1 mod Q: odd values become even by adding Q first.
    function automatic logic [WID-1:0] mod_half(input logic [WID-1:0] x);
        logic [WID:0] s;
        s = x[0] ? ({1'b0, x} + {1'b0, QV}) : {1'b0, x};
        return s[WID:1];
    endfunction

    logic       w_en;
    logic [4:1] r_vld;          // r_vld[4] is the output valid

    // S1
    logic [WID-1:0]   r1_a, r1_b, r1_w;
    logic             r1_sel, r1_half;
    logic [TAG_W-1:0] r1_tag;
    // S2
    logic [PW-1:0]    r2_prod;
    logic [WID-1:0]   r2_a;
    logic             r2_sel, r2_half;
    logic [TAG_W-1:0] r2_tag;
    // S3
    logic [WID-1:0]   r3_p, r3_a;
    logic             r3_sel, r3_half;
    logic [TAG_W-1:0] r3_tag;
    // S4 (outputs)
    logic [WID-1:0]   r_s0, r_s1;
    logic [TAG_W-1:0] r_tag;

    logic [WID-1:0]   w_pre_a, w_pre_b;
    logic [XW-1:0]    w_xm;
    logic [PW-1:0]    w_qt, w_qq, w_r;
    logic [WID-1:0]   w_red;
    logic [WID-1:0]   w_s0, w_s1;

    assign w_en = ~bus.hold;

    // NTT multiplies t by w; INTT multiplies (u-t) by w and keeps (u+t).
    always_comb begin
        w_pre_a = bus.u;
        w_pre_b = bus.t;
        if (!bus.sel) begin
            w_pre_a = mod_add(bus.u, bus.t);
            w_pre_b = mod_sub(bus.u, bus.t);
        end
    end

    // Barrett: quotient estimate is at most one short, so r < 2Q.
    always_comb begin
        w_xm  = XW'(r2_prod) * M;
        w_qt  = w_xm[XW-1:BK];
        w_qq  = w_qt * PW'(Q);
        w_r   = r2_prod - w_qq;
        w_red = (w_r >= PW'(Q)) ? WID'(w_r - PW'(Q)) : WID'(w_r);
    end

    always_comb begin
        w_s0 = r3_a;
        w_s1 = r3_p;
        if (r3_sel) begin
            w_s0 = mod_add(r3_a, r3_p);
            w_s1 = mod_sub(r3_a, r3_p);
        end else if (r3_half) begin
            w_s0 = mod_half(r3_a);
            w_s1 = mod_half(r3_p);
        end
    end

    // Stage data: no reset needed, contents of invalid stages are don't-care.
    always_ff @(posedge i_clk) begin
        if (w_en && bus.in_valid) begin
            r1_a    <= w_pre_a;
            r1_b    <= w_pre_b;
            r1_w    <= bus.w;
            r1_sel  <= bus.sel;
            r1_half <= bus.half;
            r1_tag  <= bus.in_tag;
        end
        if (w_en) begin
            r2_prod <= PW'(r1_b) * PW'(r1_w);
            r2_a    <= r1_a;
            r2_sel  <= r1_sel;
            r2_half <= r1_half;
            r2_tag  <= r1_tag;
            r3_p    <= w_red;
            r3_a    <= r2_a;
            r3_sel  <= r2_sel;
            r3_half <= r2_half;
            r3_tag  <= r2_tag;
        end
    end

    // Valids and visible outputs; outputs only move when a real sample lands.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_vld <= '0;
            r_s0  <= '0;
            r_s1  <= '0;
            r_tag <= '0;
        end else if (w_en) begin
            r_vld <= {r_vld[3:1], bus.in_valid};
            if (r_vld[3]) begin
                r_s0  <= w_s0;
                r_s1  <= w_s1;
                r_tag <= r3_tag;
            end
        end
    end

    assign bus.out_valid = r_vld[4];
    assign bus.s0        = r_s0;
    assign bus.s1        = r_s1;
    assign bus.out_tag   = r_tag;
endmodule
